// File: rtl/maria_dma_responder.sv
// Maria DMA read responder: decodes Maria's DMA address onto RAM, BIOS or
// cartridge, runs one memory handshake at a time, and returns the byte to
// Maria. A repeated address skips the fetch.
module maria_dma_responder #(
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic        sysclk,
    input  logic        reset_b,
    input  logic [15:0] dma_addr,
    input  logic        dma_drive,
    input  logic        bios_en,
    output logic [7:0]  dma_data,
    output logic        dma_valid,
    output logic        dma_stall,
    output logic        mem_req,
    output logic [1:0]  mem_sel,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        timeout_err
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned SW = 2;

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [SW-1:0] SEL_RAM   = SW'(0);
    localparam logic [SW-1:0] SEL_BIOS  = SW'(1);
    localparam logic [SW-1:0] SEL_CART  = SW'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic          run_q;
    logic          mem_req_n, dma_valid_n, dma_stall_n, timeout_err_n;
    logic [SW-1:0] mem_sel_n;
    logic [AW-1:0] mem_addr_n;
    logic [DW-1:0] dma_data_n;
    logic [AW-1:0] last_addr_q, last_addr_n;
    logic          last_valid_q, last_valid_n;
    logic          bios_q;
    logic          abort_q, abort_n;
    logic [CW-1:0] wait_q, wait_n, wait_inc;

    logic          dec_hit;
    logic [SW-1:0] dec_sel;
    logic [AW-1:0] dec_off;
    logic          addr_known;
    logic          abort_eff;

    // Reset release is retimed so the first capture lands on the second edge
    always_ff @(posedge sysclk or negedge reset_b) begin
        if (!reset_b) run_q <= 1'b0;
        else          run_q <= 1'b1;
    end

    // Address decode with RAM > BIOS > cartridge priority
    always_comb begin
        dec_hit = 1'b1;
        dec_sel = SEL_RAM;
        dec_off = '0;
        if (dma_addr >= 16'h1800 && dma_addr <= 16'h27FF) begin
            dec_sel = SEL_RAM;
            dec_off = dma_addr - 16'h1800;
        end else if (bios_en && dma_addr >= 16'hF000) begin
            dec_sel = SEL_BIOS;
            dec_off = dma_addr - 16'hF000;
        end else if (dma_addr >= 16'h4000) begin
            dec_sel = SEL_CART;
            dec_off = dma_addr - 16'h4000;
        end else begin
            dec_hit = 1'b0;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n       = state_q;
        mem_req_n     = mem_req;
        mem_sel_n     = mem_sel;
        mem_addr_n    = mem_addr;
        dma_data_n    = dma_data;
        dma_valid_n   = 1'b0;
        dma_stall_n   = dma_stall;
        timeout_err_n = timeout_err;
        last_addr_n   = last_addr_q;
        abort_n       = abort_q;
        wait_n        = wait_q;
        wait_inc      = (wait_q == {CW{1'b1}}) ? wait_q : wait_q + CW'(1);
        abort_eff     = abort_q | ~dma_drive;
        // A bios_en edge makes the remembered address stale
        addr_known    = last_valid_q & ~(bios_en ^ bios_q);
        last_valid_n  = addr_known;

        case (state_q)
            S_IDLE: begin
                if (run_q && dma_drive && (!addr_known || dma_addr != last_addr_q)) begin
                    last_addr_n  = dma_addr;
                    last_valid_n = 1'b1;
                    abort_n      = 1'b0;
                    wait_n       = '0;
                    if (dec_hit) begin
                        state_n     = S_REQ;
                        mem_req_n   = 1'b1;
                        mem_sel_n   = dec_sel;
                        mem_addr_n  = dec_off;
                        dma_stall_n = 1'b1;
                    end else begin
                        state_n     = S_DONE;
                        dma_data_n  = OPEN_BUS;
                        dma_valid_n = 1'b1;
                    end
                end
            end
            S_REQ: begin
                abort_n = abort_eff;
                if (mem_ack) begin
                    state_n     = S_DONE;
                    mem_req_n   = 1'b0;
                    dma_data_n  = mem_rdata;
                    dma_valid_n = ~abort_eff;
                    if (abort_eff) last_valid_n = 1'b0;
                end else if (wait_inc >= TIMEOUT_C) begin
                    state_n       = S_DONE;
                    mem_req_n     = 1'b0;
                    dma_data_n    = OPEN_BUS;
                    timeout_err_n = 1'b1;
                    dma_valid_n   = ~abort_eff;
                    wait_n        = wait_inc;
                    if (abort_eff) last_valid_n = 1'b0;
                end else begin
                    wait_n = wait_inc;
                end
            end
            S_DONE: begin
                state_n     = S_IDLE;
                dma_stall_n = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge sysclk or negedge reset_b) begin
        if (!reset_b) begin
            state_q      <= S_IDLE;
            mem_req      <= 1'b0;
            mem_sel      <= SEL_RAM;
            mem_addr     <= '0;
            dma_data     <= OPEN_BUS;
            dma_valid    <= 1'b0;
            dma_stall    <= 1'b0;
            timeout_err  <= 1'b0;
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
            bios_q       <= 1'b0;
            abort_q      <= 1'b0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_n;
            mem_req      <= mem_req_n;
            mem_sel      <= mem_sel_n;
            mem_addr     <= mem_addr_n;
            dma_data     <= dma_data_n;
            dma_valid    <= dma_valid_n;
            dma_stall    <= dma_stall_n;
            timeout_err  <= timeout_err_n;
            last_addr_q  <= last_addr_n;
            last_valid_q <= last_valid_n;
            bios_q       <= bios_en;
            abort_q      <= abort_n;
            wait_q       <= wait_n;
        end
    end

endmodule

// File: tb/tb_maria_dma_responder.sv
// Self-checking bench for maria_dma_responder: table of DMA transactions with
// a memory model and a scoreboard of returned bytes, plus hand sequences for
// repeated-address hits, abort and reset during a request.
module tb_maria_dma_responder;

    localparam logic [7:0] OPEN_BUS = 8'hFF;
    localparam int         TMO      = 15;

    logic        sysclk = 1'b0;
    logic        reset_b;
    logic [15:0] dma_addr;
    logic        dma_drive;
    logic        bios_en;
    logic [7:0]  dma_data;
    logic        dma_valid;
    logic        dma_stall;
    logic        mem_req;
    logic [1:0]  mem_sel;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic       terr_m = 1'b0;

    typedef struct {
        logic [15:0] addr;
        logic        bios;
        int          delay;   // ack delay in REQ cycles, -1 = never
        logic [7:0]  rdata;
        logic        mapped;
        logic [1:0]  sel;
        logic [15:0] off;
    } vec_t;

    vec_t vecs[11];

    maria_dma_responder #(.TIMEOUT(TMO), .OPEN_BUS(OPEN_BUS)) dut (
        .sysclk      (sysclk),
        .reset_b     (reset_b),
        .dma_addr    (dma_addr),
        .dma_drive   (dma_drive),
        .bios_en     (bios_en),
        .dma_data    (dma_data),
        .dma_valid   (dma_valid),
        .dma_stall   (dma_stall),
        .mem_req     (mem_req),
        .mem_sel     (mem_sel),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .timeout_err (timeout_err)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every dma_valid pulse must match the oldest expected byte
    always @(negedge sysclk) begin
        if (reset_b === 1'b1 && dma_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=%0h expected=none", dma_data);
            end else begin
                check("sb_data", dma_data, exp_q.pop_front());
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int   k;
        logic unstable;
        dma_addr  = v.addr;
        bios_en   = v.bios;
        dma_drive = 1'b1;
        exp_q.push_back((v.mapped && v.delay >= 0) ? v.rdata : OPEN_BUS);
        @(negedge sysclk);
        if (v.mapped) begin
            check("req_issued", mem_req, 1);
            check("stall_req", dma_stall, 1);
            check("sel", mem_sel, v.sel);
            check("off", mem_addr, v.off);
            k = 0;
            unstable = 1'b0;
            while (mem_req && k < 40) begin
                if (mem_sel != v.sel || mem_addr != v.off) unstable = 1'b1;
                mem_ack   = (k == v.delay);
                mem_rdata = v.rdata;
                @(negedge sysclk);
                k++;
            end
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            check("req_stable", unstable, 0);
            check("req_cycles", k, (v.delay < 0) ? TMO : v.delay + 1);
            if (v.delay < 0) terr_m = 1'b1;
        end else begin
            check("no_req", mem_req, 0);
        end
        check("valid_pulse", dma_valid, 1);
        check("terr", timeout_err, terr_m);
        @(negedge sysclk);
        check("idle_stall", dma_stall, 0);
        check("valid_one_cycle", dma_valid, 0);
    endtask

    initial begin
        int cnt;
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        vecs[0]  = '{16'h1800, 1'b0,  0, 8'h5A, 1'b1, 2'd0, 16'h0000};
        vecs[1]  = '{16'h27FF, 1'b0,  2, 8'h3C, 1'b1, 2'd0, 16'h0FFF};
        vecs[2]  = '{16'hF123, 1'b1,  1, 8'hA5, 1'b1, 2'd1, 16'h0123};
        vecs[3]  = '{16'hF123, 1'b0,  0, 8'h11, 1'b1, 2'd2, 16'hB123};
        vecs[4]  = '{16'h4000, 1'b0, -1, 8'h00, 1'b1, 2'd2, 16'h0000};
        vecs[5]  = '{16'h0280, 1'b0,  0, 8'h00, 1'b0, 2'd0, 16'h0000};
        vecs[6]  = '{16'h3FFF, 1'b0,  0, 8'h00, 1'b0, 2'd0, 16'h0000};
        vecs[7]  = '{16'hEFFF, 1'b1,  1, 8'h77, 1'b1, 2'd2, 16'hAFFF};
        vecs[8]  = '{16'h17FF, 1'b1,  0, 8'h00, 1'b0, 2'd0, 16'h0000};
        vecs[9]  = '{16'hFFFF, 1'b1,  3, 8'hC3, 1'b1, 2'd1, 16'h0FFF};
        vecs[10] = '{16'h2800, 1'b1,  0, 8'h00, 1'b0, 2'd0, 16'h0000};

        reset_b   = 1'b0;
        dma_addr  = 16'h0000;
        dma_drive = 1'b0;
        bios_en   = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        repeat (2) @(negedge sysclk);
        check("rst_data", dma_data, OPEN_BUS);
        check("rst_valid", dma_valid, 0);
        check("rst_stall", dma_stall, 0);
        check("rst_req", mem_req, 0);
        check("rst_sel", mem_sel, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_terr", timeout_err, 0);
        reset_b = 1'b1;
        repeat (3) @(negedge sysclk);

        for (int i = 0; i < 11; i++) run_txn(vecs[i]);

        // Unmapped capture, then the same address held: no more activity,
        // and a stray mem_ack outside REQ changes nothing
        dma_addr = 16'h0280;
        exp_q.push_back(OPEN_BUS);
        @(negedge sysclk);
        check("unmapped_valid", dma_valid, 1);
        check("unmapped_noreq", mem_req, 0);
        @(negedge sysclk);
        mem_ack   = 1'b1;
        mem_rdata = 8'h12;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sysclk);
            if (dma_valid || mem_req) cnt++;
        end
        mem_ack = 1'b0;
        check("hit_quiet", cnt, 0);
        check("hit_data_held", dma_data, OPEN_BUS);

        // Abort: drive drops in REQ, ack three cycles later
        dma_addr = 16'h1900;
        @(negedge sysclk);
        check("abort_req", mem_req, 1);
        dma_drive = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            if (mem_req) cnt++;
        end
        check("abort_req_held", cnt, 3);
        mem_ack   = 1'b1;
        mem_rdata = 8'h99;
        @(negedge sysclk);
        mem_ack = 1'b0;
        check("abort_req_drop", mem_req, 0);
        check("abort_no_valid", dma_valid, 0);
        @(negedge sysclk);
        dma_drive = 1'b1;
        @(negedge sysclk);
        check("abort_refetch", mem_req, 1);
        check("abort_refetch_off", mem_addr, 16'h0100);
        mem_ack   = 1'b1;
        mem_rdata = 8'h42;
        exp_q.push_back(8'h42);
        @(negedge sysclk);
        mem_ack = 1'b0;
        check("refetch_valid", dma_valid, 1);
        @(negedge sysclk);

        // Reset during REQ, then synchronized release
        dma_addr = 16'h5000;
        @(negedge sysclk);
        check("pre_rst_req", mem_req, 1);
        #2 reset_b = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_stall", dma_stall, 0);
        check("mid_rst_data", dma_data, OPEN_BUS);
        check("mid_rst_terr", timeout_err, 0);
        check("mid_rst_sel", mem_sel, 0);
        check("mid_rst_addr", mem_addr, 0);
        terr_m = 1'b0;
        @(negedge sysclk);
        reset_b = 1'b1;
        @(negedge sysclk);
        check("sync_edge1", mem_req, 0);
        @(negedge sysclk);
        check("first_capture", mem_req, 1);
        check("first_capture_off", mem_addr, 16'h1000);
        mem_ack   = 1'b1;
        mem_rdata = 8'h6E;
        exp_q.push_back(8'h6E);
        @(negedge sysclk);
        mem_ack = 1'b0;
        check("post_rst_valid", dma_valid, 1);

        dma_drive = 1'b0;
        repeat (3) @(negedge sysclk);
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maria_dma_responder.md
MARIA_DMA_RESPONDER -- requirements
Module: maria_dma_responder

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum sysclk cycles spent in REQ awaiting mem_ack.
REQ-002 Parameter OPEN_BUS, default 8'hFF: data value returned for unmapped addresses and timeouts.
REQ-003 sysclk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_b  in  1  asynchronous, active-low reset.
REQ-005 dma_addr  in  16  DMA address driven by Maria.
REQ-006 dma_drive  in  1  high while Maria owns the address bus for DMA.
REQ-007 bios_en  in  1  high maps BIOS over 0xF000-0xFFFF.
REQ-008 dma_data  out  8  read data returned to Maria's read data bus.
REQ-009 dma_valid  out  1  one-cycle pulse; dma_data is valid this cycle.
REQ-010 dma_stall  out  1  high while a request is outstanding.
REQ-011 mem_req  out  1  memory request, level, held until acknowledged.
REQ-012 mem_sel  out  2  target: 0 RAM, 1 BIOS, 2 cartridge.
REQ-013 mem_addr  out  16  target-relative byte offset.
REQ-014 mem_ack  in  1  memory acknowledge; mem_rdata is valid in the same cycle.
REQ-015 mem_rdata  in  8  memory read data.
REQ-016 timeout_err  out  1  sticky flag; set on any timeout.

Function
REQ-017 States are IDLE, REQ and DONE, encoded in a single registered state variable.
REQ-018 A new request is captured in IDLE when dma_drive=1 and either dma_addr differs from the last captured address or no address has been captured yet.
REQ-019 Decode priority is: 0x1800-0x27FF -> RAM, offset = addr-0x1800; then bios_en=1 and 0xF000-0xFFFF -> BIOS, offset = addr-0xF000; then 0x4000-0xFFFF -> cartridge, offset = addr-0x4000; any other address is unmapped.
REQ-020 For a mapped capture, the next state is REQ, with mem_req=1, mem_sel and mem_addr registered, and dma_stall=1 from the following cycle.
REQ-021 For an unmapped capture, there is no mem_req; the next state is DONE with dma_data=OPEN_BUS.
REQ-022 In REQ, a mem_ack sampled high latches mem_rdata into dma_data, clears mem_req, and moves to DONE; minimum latency from capture to dma_valid is 2 cycles.
REQ-023 In REQ, a wait counter increments each cycle; when it reaches TIMEOUT without mem_ack, the block clears mem_req, sets dma_data=OPEN_BUS, sets timeout_err, and moves to DONE.
REQ-024 In DONE, dma_valid=1 for exactly one cycle; the next state is IDLE and dma_stall=0.
REQ-025 If dma_drive falls while in REQ, the memory handshake still completes (mem_req is not withdrawn), but dma_valid is suppressed in DONE; the last captured address is then invalidated.
REQ-026 If the same address is requested again in IDLE while the last capture is valid, there is no mem_req and no dma_valid; dma_data is held (repeated-address hit).
REQ-027 mem_ack sampled outside REQ is ignored.
REQ-028 Any edge of bios_en invalidates the last captured address.
REQ-029 The wait counter is 8 bits and saturates; TIMEOUT values above 255 are illegal.
REQ-030 The block issues at most one outstanding mem_req.
REQ-031 mem_sel and mem_addr are stable for the whole time mem_req is high.

Reset
REQ-032 While reset_b=0 the block is asynchronously forced to: state IDLE, mem_req=0, mem_sel=0, mem_addr=0, dma_data=OPEN_BUS, dma_valid=0, dma_stall=0, timeout_err=0, last-address valid=0, wait counter=0.
REQ-033 Reset asserted mid-REQ drops mem_req immediately; the memory side discards the request.
REQ-034 Release of reset_b is synchronized internally; the first capture is possible on the second sysclk edge after release.

Verification
REQ-035 RAM read: dma_addr=0x1800, dma_drive=1, mem_ack on the first REQ cycle with rdata=0x5A -> mem_sel=0, mem_addr=0x0000, dma_valid pulse with dma_data=0x5A two cycles after capture.
REQ-036 BIOS/cart decode: addr=0xF123 with bios_en=1 -> mem_sel=1, mem_addr=0x0123; same address with bios_en=0 -> mem_sel=2, mem_addr=0xB123.
REQ-037 Unmapped and hit: addr=0x0280 -> no mem_req, dma_valid with dma_data=0xFF; hold addr=0x0280 for 5 cycles -> no further dma_valid.
REQ-038 Timeout: addr=0x4000, mem_ack never asserted -> mem_req high for exactly 15 cycles, then dma_data=0xFF, dma_valid pulse, timeout_err=1 until reset.
REQ-039 Abort: dma_drive drops in REQ, mem_ack arrives 3 cycles later -> mem_req held until the ack, dma_valid stays 0, and the next capture of the same address issues mem_req again.
REQ-040 Reset mid-REQ: reset_b=0 during REQ -> mem_req=0 and dma_stall=0 in the same cycle; all outputs at their REQ-032 values.
